// File: rtl/rng_tx_scheduler_pkg.sv
// Shared definitions for the random-byte transmit scheduler: Tx FSM state
// encoding, default sizing constants and a saturating counter helper.
package rng_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_RCT_CUTOFF = 32;

  // Increment an 8-bit counter, holding at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      sat_inc8 = value;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/rng_tx_scheduler_fifo.sv
// Byte FIFO between the bit assembler and the transmit FSM. The head entry is
// presented combinationally on dout; flush has priority over push and pop.
module rng_tx_scheduler_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level     = wr_ptr_r - rd_ptr_r;
  assign empty     = (level == (AW + 1)'(0));
  assign full      = (level == (AW + 1)'(DEPTH));
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push_s = push & ~flush & (~full | pop);
  assign do_pop_s  = pop & ~flush & ~empty;

  // Advance read/write pointers; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
    end
  end

  // Storage array write port; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rng_tx_scheduler.sv
// Collects de-biased random bits into LSB-first bytes, buffers them and paces
// them onto the UART one byte per tx_ready handshake. A repetition-count
// health test raises a sticky alarm on a stuck source and blanks the output.
module rng_tx_scheduler
  import rng_tx_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          bit_valid,
  input  logic                          bit_in,
  input  logic                          clear_alarm,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic [7:0]                    tx_byte,
  output logic                          alarm,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [2:0] bit_cnt_r;
  logic [6:0] temp_r;
  logic       last_bit_r;
  logic [7:0] rct_cnt_r;
  logic       alarm_r;
  logic       overflow_r;
  logic [7:0] drop_cnt_r;
  tx_state_e  state_r;
  tx_state_e  state_s;
  logic [7:0] tx_byte_r;
  logic       tx_start_r;

  logic       bit_take_s;
  logic       rct_take_s;
  logic [7:0] rct_next_s;
  logic       trip_s;
  logic       byte_done_s;
  logic [7:0] byte_s;
  logic       pop_s;
  logic       drop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [7:0] fifo_dout_s;

  // The health test sees every enabled bit; assembly also stops while alarmed.
  assign rct_take_s  = bit_valid & enable;
  assign bit_take_s  = rct_take_s & ~alarm_r;
  assign rct_next_s  = (bit_in == last_bit_r) ? sat_inc8(rct_cnt_r) : 8'd1;
  assign trip_s      = rct_take_s & (rct_next_s == 8'(RCT_CUTOFF));
  assign byte_done_s = bit_take_s & (bit_cnt_r == 3'd7);
  // temp_r shifts right, so after seven bits temp_r[0] holds the first (LSB).
  assign byte_s      = {bit_in, temp_r};
  // A byte completed by the tripping bit is flushed, not counted as a drop.
  assign drop_s      = byte_done_s & ~trip_s & fifo_full_s & ~pop_s;

  rng_tx_scheduler_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (trip_s),
    .push  (byte_done_s),
    .pop   (pop_s),
    .din   (byte_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Byte assembler: shift accepted bits in, discard the partial byte on alarm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r <= 3'd0;
      temp_r    <= 7'd0;
    end else if (trip_s) begin
      bit_cnt_r <= 3'd0;
      temp_r    <= 7'd0;
    end else if (bit_take_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      temp_r    <= byte_done_s ? 7'd0 : {bit_in, temp_r[6:1]};
    end
  end

  // Repetition-count test; a tripping bit outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_bit_r <= 1'b0;
      rct_cnt_r  <= 8'd0;
      alarm_r    <= 1'b0;
    end else begin
      if (rct_take_s) last_bit_r <= bit_in;
      if (trip_s) begin
        rct_cnt_r <= rct_next_s;
        alarm_r   <= 1'b1;
      end else if (clear_alarm) begin
        rct_cnt_r <= 8'd0;
        alarm_r   <= 1'b0;
      end else if (rct_take_s) begin
        rct_cnt_r <= rct_next_s;
      end
    end
  end

  // Sticky overflow flag and saturating dropped-byte counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      drop_cnt_r <= sat_inc8(drop_cnt_r);
    end
  end

  // Tx FSM next state; a pop only happens in IDLE so tx_byte never moves mid-send.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (~fifo_empty_s & tx_ready & ~alarm_r & ~trip_s) begin
          pop_s   = 1'b1;
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND:      state_s = ST_WAIT_BUSY;
      ST_WAIT_BUSY: state_s = tx_ready ? ST_WAIT_BUSY : ST_WAIT_DONE;
      ST_WAIT_DONE: state_s = tx_ready ? ST_IDLE : ST_WAIT_DONE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // Tx FSM state register plus registered start pulse and byte latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      tx_start_r <= 1'b0;
      tx_byte_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      tx_start_r <= (state_s == ST_SEND);
      if (pop_s) tx_byte_r <= fifo_dout_s;
    end
  end

  assign tx_start   = tx_start_r;
  assign tx_byte    = tx_byte_r;
  assign alarm      = alarm_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_cnt_r;

endmodule

// File: tb/tb_rng_tx_scheduler.sv
// Directed self-checking bench for rng_tx_scheduler (FIFO_DEPTH=8, RCT_CUTOFF=32).
module tb_rng_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       bit_valid;
  logic       bit_in;
  logic       clear_alarm;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       alarm;
  logic       overflow;
  logic [7:0] drop_count;
  logic [3:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  rng_tx_scheduler #(.FIFO_DEPTH(8), .RCT_CUTOFF(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .clear_alarm (clear_alarm),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .alarm       (alarm),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    enable      = 1'b1;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    clear_alarm = 1'b0;
    tx_ready    = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic wait_start(input int budget, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      if (tx_start === 1'b1) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  // Called in the SEND cycle: emulate the UART going busy and then idle.
  task automatic finish_handshake();
    tick();
    tx_ready = 1'b0;
    tick();
    tx_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx_start, tx_byte, alarm, overflow, drop_count, fifo_level} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got start=%b byte=%h alarm=%b ovf=%b drops=%0d level=%0d exp all 0",
               tx_start, tx_byte, alarm, overflow, drop_count, fifo_level);
    end
  endtask

  task automatic test_basic();
    bit seen;
    int cyc;
    do_reset();
    send_byte(8'h4D);
    checks++;
    if (fifo_level !== 4'd1 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL basic_push got level=%0d start=%b exp level=1 start=0", fifo_level, tx_start);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency got start=%b exp 1 two cycles after 8th bit", tx_start);
    end
    checks++;
    if (tx_byte !== 8'h4D) begin
      failures++;
      $display("FAIL basic_byte1 got %h exp 4d", tx_byte);
    end
    tick();
    checks++;
    if (tx_start !== 1'b0 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL basic_pulse_width got start=%b level=%0d exp start=0 level=0", tx_start, fifo_level);
    end
    tx_ready = 1'b0;
    tick();
    tx_ready = 1'b1;
    tick();
    send_byte(8'h4D);
    wait_start(6, seen, cyc);
    checks++;
    if (!seen || tx_byte !== 8'h4D) begin
      failures++;
      $display("FAIL basic_byte2 got seen=%b byte=%h exp seen=1 byte=4d", seen, tx_byte);
    end
    finish_handshake();
  endtask

  task automatic test_overflow();
    bit seen;
    int cyc;
    logic [7:0] exp_q [10];
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q[i] = 8'h31 + 8'(7 * i);
      send_byte(exp_q[i]);
      if (i == 7) begin
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_exact_full got level=%0d ovf=%b exp level=8 ovf=0", fifo_level, overflow);
        end
      end
    end
    checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      failures++;
      $display("FAIL ovf_state got level=%0d ovf=%b drops=%0d exp level=8 ovf=1 drops=2",
               fifo_level, overflow, drop_count);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start(10, seen, cyc);
      checks++;
      if (!seen || tx_byte !== exp_q[i]) begin
        failures++;
        $display("FAIL ovf_order_%0d got seen=%b byte=%h exp %h", i, seen, tx_byte, exp_q[i]);
      end
      finish_handshake();
    end
    wait_start(10, seen, cyc);
    checks++;
    if (seen || fifo_level !== 4'd0 || drop_count !== 8'd2) begin
      failures++;
      $display("FAIL ovf_drained got extra_start=%b level=%0d drops=%0d exp 0/0/2", seen, fifo_level, drop_count);
    end
  endtask

  task automatic test_alarm();
    bit seen;
    int cyc;
    bit spurious;
    do_reset();
    tx_ready = 1'b0;
    repeat (3)  send_bit(1'b0);
    repeat (31) send_bit(1'b1);
    checks++;
    if (alarm !== 1'b0 || fifo_level !== 4'd4) begin
      failures++;
      $display("FAIL rct_below_cutoff got alarm=%b level=%0d exp alarm=0 level=4", alarm, fifo_level);
    end
    send_bit(1'b1);
    checks++;
    if (alarm !== 1'b1 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL rct_trip got alarm=%b level=%0d exp alarm=1 level=0", alarm, fifo_level);
    end
    tx_ready = 1'b1;
    spurious = 1'b0;
    repeat (20) begin
      tick();
      if (tx_start !== 1'b0) spurious = 1'b1;
    end
    send_byte(8'h4D);
    checks++;
    if (spurious || fifo_level !== 4'd0 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL alarm_blanking got start_seen=%b level=%0d alarm=%b exp 0/0/1", spurious, fifo_level, alarm);
    end
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    checks++;
    if (alarm !== 1'b0) begin
      failures++;
      $display("FAIL alarm_clear got %b exp 0", alarm);
    end
    send_byte(8'h4D);
    wait_start(6, seen, cyc);
    checks++;
    if (!seen || tx_byte !== 8'h4D) begin
      failures++;
      $display("FAIL alarm_resume got seen=%b byte=%h exp seen=1 byte=4d", seen, tx_byte);
    end
    finish_handshake();
    do_reset();
    tx_ready = 1'b0;
    repeat (31) send_bit(1'b1);
    clear_alarm = 1'b1;
    send_bit(1'b1);
    clear_alarm = 1'b0;
    checks++;
    if (alarm !== 1'b1) begin
      failures++;
      $display("FAIL clear_vs_trip got alarm=%b exp 1", alarm);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int cyc;
    bit moved;
    do_reset();
    tx_ready = 1'b0;
    send_byte(8'h4D);
    send_byte(8'h3C);
    tx_ready = 1'b1;
    wait_start(5, seen, cyc);
    checks++;
    if (!seen || tx_byte !== 8'h4D) begin
      failures++;
      $display("FAIL b2b_first got seen=%b byte=%h exp seen=1 byte=4d", seen, tx_byte);
    end
    tick();
    tx_ready = 1'b0;
    moved = 1'b0;
    repeat (100) begin
      tick();
      if (tx_byte !== 8'h4D || tx_start !== 1'b0) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      failures++;
      $display("FAIL b2b_hold got byte_or_start_changed=1 exp 0");
    end
    tx_ready = 1'b1;
    tick();
    checks++;
    if (tx_start !== 1'b0 || tx_byte !== 8'h4D) begin
      failures++;
      $display("FAIL b2b_return got start=%b byte=%h exp start=0 byte=4d", tx_start, tx_byte);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1 || tx_byte !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_second got start=%b byte=%h exp start=1 byte=3c", tx_start, tx_byte);
    end
    finish_handshake();
  endtask

  task automatic test_async_reset();
    bit seen;
    int cyc;
    do_reset();
    tx_ready = 1'b0;
    send_byte(8'h4D);
    send_byte(8'h3C);
    send_byte(8'hA5);
    send_byte(8'h5A);
    tx_ready = 1'b1;
    wait_start(5, seen, cyc);
    tick();
    tx_ready = 1'b0;
    tick();
    checks++;
    if (!seen || fifo_level !== 4'd3 || tx_byte !== 8'h4D) begin
      failures++;
      $display("FAIL areset_setup got seen=%b level=%0d byte=%h exp 1/3/4d", seen, fifo_level, tx_byte);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || fifo_level !== 4'd0 || alarm !== 1'b0 ||
        drop_count !== 8'd0 || tx_byte !== 8'h00) begin
      failures++;
      $display("FAIL areset_immediate got start=%b level=%0d alarm=%b drops=%0d byte=%h exp all 0",
               tx_start, fifo_level, alarm, drop_count, tx_byte);
    end
    @(negedge clk);
    reset    = 1'b1;
    tx_ready = 1'b1;
    tick();
  endtask

  task automatic test_enable_gap();
    bit seen;
    int cyc;
    logic [7:0] v;
    do_reset();
    v = 8'h4D;
    for (int i = 0; i < 5; i++) send_bit(v[i]);
    enable    = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (40) tick();
    bit_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd0 || alarm !== 1'b0 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL enable_gap_idle got level=%0d alarm=%b start=%b exp 0/0/0", fifo_level, alarm, tx_start);
    end
    enable = 1'b1;
    for (int i = 5; i < 8; i++) send_bit(v[i]);
    wait_start(6, seen, cyc);
    checks++;
    if (!seen || tx_byte !== 8'h4D) begin
      failures++;
      $display("FAIL enable_gap_byte got seen=%b byte=%h exp seen=1 byte=4d", seen, tx_byte);
    end
    finish_handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_alarm();
    test_back_to_back();
    test_async_reset();
    test_enable_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
